// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU; S1 holds captured operands, S2 holds the registered result and flags.
// The sticky overflow flag records delivered overflows until it is cleared.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);
    localparam int SW = $clog2(WIDTH);

    generate
        if (WIDTH != 4 && WIDTH != 8 && WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
            $error("alu_pipe: WIDTH must be a power of two from 4 to 64");
        end
    endgenerate

    logic             s1_valid_q, out_valid_q, sticky_q;
    logic [WIDTH-1:0] a_q, b_q, result_q, res_d;
    logic [2:0]       op_q;
    logic             z_q, n_q, c_q, v_q, c_d, v_d, advance;
    logic [SW-1:0]    sh;
    logic [WIDTH:0]   sum, diff, shl, shr;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || advance;
    assign sh        = b_q[SW-1:0];
    assign sum       = {1'b0, a_q} + {1'b0, b_q};
    assign diff      = {1'b0, a_q} - {1'b0, b_q};
    // Extra bit on the far side of each shift captures the last bit shifted out.
    assign shl       = {1'b0, a_q} << sh;
    assign shr       = {a_q, 1'b0} >> sh;

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (op_q)
            3'b000: begin
                {c_d, res_d} = sum;
                v_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: begin
                {c_d, res_d} = diff;
                v_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010: res_d = a_q & b_q;
            3'b011: res_d = a_q | b_q;
            3'b100: res_d = a_q ^ b_q;
            3'b101: {c_d, res_d} = shl;
            3'b110: {res_d, c_d} = shr;
            default: res_d = ~a_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else if (advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= res_d;
                z_q      <= ~|res_d;
                n_q      <= res_d[WIDTH-1];
                c_q      <= c_d;
                v_q      <= v_d;
            end
        end
    end

    // Set beats clear when a delivered overflow coincides with clr_sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            sticky_q <= 1'b0;
        else if (out_valid_q && out_ready && v_q) sticky_q <= 1'b1;
        else if (clr_sticky)                   sticky_q <= 1'b0;
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = z_q;
    assign negative   = n_q;
    assign carry      = c_q;
    assign overflow   = v_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed corner cases followed by a randomized valid/ready run
// checked against an integer-arithmetic reference model and a result queue.
module tb_alu_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0, clr_sticky = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0]   op = '0;
    logic         in_ready, out_valid, zero, negative, carry, overflow, ovf_sticky;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;
    logic [11:0] q[$];
    logic        exp_sticky;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Returns {result, zero, negative, carry, overflow} from plain integer arithmetic.
    function automatic logic [11:0] model(int ua, int ub, int uop);
        int m = 1 << W;
        int sa = (ua >= m / 2) ? ua - m : ua;
        int sb = (ub >= m / 2) ? ub - m : ub;
        int sh = ub % W;
        int r = 0, c = 0, v = 0, s;
        case (uop)
            0: begin r = ua + ub; c = int'(r >= m); s = sa + sb; v = int'(s >= m / 2 || s < -m / 2); r = r % m; end
            1: begin r = (ua - ub + m) % m; c = int'(ua < ub); s = sa - sb; v = int'(s >= m / 2 || s < -m / 2); end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: begin r = (ua << sh) % m; c = (sh > 0) ? (ua >> (W - sh)) & 1 : 0; end
            6: begin r = ua >> sh; c = (sh > 0) ? (ua >> (sh - 1)) & 1 : 0; end
            default: r = (m - 1) - ua;
        endcase
        return {r[7:0], r == 0, r >= m / 2, c[0], v[0]};
    endfunction

    task automatic run1(string tag, logic [7:0] ta, logic [7:0] tb_, logic [2:0] top, logic [11:0] expv, bit clr);
        a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = 1'b0;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        chk({tag, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, out_valid, 1);
        chk({tag, "_res"}, {result, zero, negative, carry, overflow}, expv);
        out_ready = 1'b1; clr_sticky = clr;
        @(posedge clk); #1;
        out_ready = 1'b0; clr_sticky = 1'b0;
        chk({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_flags", {result, zero, negative, carry, overflow}, 0);
        chk("rst_sticky", ovf_sticky, 0);
        @(negedge clk) rst_n = 1'b1;

        // Single operations with hand-derived expectations
        run1("add_ff_01", 8'hFF, 8'h01, 3'b000, {8'h00, 4'b1010}, 0);
        chk("sticky_after_noovf", ovf_sticky, 0);
        run1("add_7f_01", 8'h7F, 8'h01, 3'b000, {8'h80, 4'b0101}, 0);
        chk("sticky_set", ovf_sticky, 1);
        clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
        chk("sticky_clr", ovf_sticky, 0);
        run1("add_ovf_clr", 8'h7F, 8'h01, 3'b000, {8'h80, 4'b0101}, 1);
        chk("sticky_set_wins", ovf_sticky, 1);
        clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
        chk("sticky_clr2", ovf_sticky, 0);
        run1("sub_05_07", 8'h05, 8'h07, 3'b001, {8'hFE, 4'b0110}, 0);
        chk("sticky_sub_noovf", ovf_sticky, 0);
        run1("sub_80_01", 8'h80, 8'h01, 3'b001, {8'h7F, 4'b0001}, 0);
        run1("shr_81_1", 8'h81, 8'h01, 3'b110, {8'h40, 4'b0010}, 0);
        run1("shl_81_3", 8'h81, 8'h03, 3'b101, {8'h08, 4'b0000}, 0);
        run1("shl_81_0", 8'h81, 8'h00, 3'b101, {8'h81, 4'b0100}, 0);
        run1("not_0f", 8'h0F, 8'hAA, 3'b111, {8'hF0, 4'b0100}, 0);
        run1("and", 8'hCC, 8'hAA, 3'b010, {8'h88, 4'b0100}, 0);
        run1("or", 8'hCC, 8'h33, 3'b011, {8'hFF, 4'b0100}, 0);
        run1("xor", 8'h5A, 8'h5A, 3'b100, {8'h00, 4'b1000}, 0);

        // Back-to-back with a stalled consumer
        out_ready = 1'b0; op = 3'b000; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        #1 chk("b2b_rdy1", in_ready, 1);
        @(posedge clk); #1; a = 8'h10; b = 8'h20;
        #1 chk("b2b_rdy2", in_ready, 1);
        @(posedge clk); #1; a = 8'h30; b = 8'h40;
        #1 chk("b2b_rdy3_blocked", in_ready, 0);
        chk("b2b_head", {out_valid, result}, {1'b1, 8'h03});
        @(posedge clk); #1;
        chk("b2b_still_blocked", in_ready, 0);
        chk("b2b_stable1", {out_valid, result, zero, carry}, {1'b1, 8'h03, 2'b00});
        @(posedge clk); #1;
        chk("b2b_stable2", {out_valid, result}, {1'b1, 8'h03});
        out_ready = 1'b1;
        #1 chk("b2b_rdy_reopen", in_ready, 1);
        @(posedge clk); #1; in_valid = 1'b0;
        chk("b2b_second", {out_valid, result}, {1'b1, 8'h30});
        @(posedge clk); #1;
        chk("b2b_third", {out_valid, result}, {1'b1, 8'h70});
        @(posedge clk); #1;
        chk("b2b_empty", out_valid, 0);
        chk("sticky_before_rst", ovf_sticky, 1);

        // Reset with two requests in flight
        out_ready = 1'b0; a = 8'h7F; b = 8'h01; op = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1; a = 8'h22;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("inflight_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_res", {result, zero, negative, carry, overflow}, 0);
        chk("async_rst_sticky", ovf_sticky, 0);
        chk("async_rst_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_stale", out_valid, 0);
        end

        // Randomized traffic against the reference model
        exp_sticky = 1'b0;
        for (int i = 0; i < 800; i++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            clr_sticky = ($urandom % 8) == 0;
            a = ($urandom % 4 == 0) ? 8'h7F + W'($urandom % 3) : W'($urandom);
            b = W'($urandom);
            op = 3'($urandom);
            if (i >= 780) in_valid = 1'b0;
            if (i >= 780) out_ready = 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) chk("rnd_spurious", out_valid, 0);
                else chk("rnd_out", {result, zero, negative, carry, overflow}, q[0]);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                exp_sticky = q[0][0] ? 1'b1 : (clr_sticky ? 1'b0 : exp_sticky);
                void'(q.pop_front());
            end else if (clr_sticky) exp_sticky = 1'b0;
            if (in_valid && in_ready) q.push_back(model(int'(a), int'(b), int'(op)));
            @(posedge clk); #1;
            chk("rnd_sticky", ovf_sticky, exp_sticky);
        end
        chk("rnd_all_delivered", q.size(), 0);
        chk("rnd_final_idle", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
